// File: rtl/nist_freq_tester_if.sv
// Bit-stream and status bundle between the TRNG source, the frequency tester
// and the active-low status pins.
interface nist_freq_tester_if;
    logic RND_in;
    logic rnd_valid;
    logic start;
    logic cont_mode;
    logic nPass1;
    logic nPass2;
    logic nBlkOK;
    logic done;
    logic busy;

    modport master (
        output RND_in, rnd_valid, start, cont_mode,
        input  nPass1, nPass2, nBlkOK, done, busy
    );

    modport slave (
        input  RND_in, rnd_valid, start, cont_mode,
        output nPass1, nPass2, nBlkOK, done, busy
    );
endinterface

// File: rtl/nist_freq_tester.sv
// Parametrised NIST SP 800-22 monobit and block-frequency tester.
// Consumes a qualified serial bit stream and reports active-low pass flags.
module nist_freq_tester #(
    parameter int SEQ_LEN     = 1024,
    parameter int BLK_LEN     = 128,
    parameter int S_MAX       = 82,
    parameter int CHI_MAX     = 2571,
    parameter int BLK_DEV_MAX = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    nist_freq_tester_if.slave   bus
);

    localparam int NW = $clog2(SEQ_LEN + 1);
    localparam int MW = $clog2(BLK_LEN + 1);
    localparam int CW = $clog2((SEQ_LEN / BLK_LEN) * BLK_LEN * BLK_LEN + 1);

    localparam logic [NW-1:0] LAST_BIT = NW'(SEQ_LEN - 1);
    localparam logic [MW-1:0] LAST_BLK = MW'(BLK_LEN - 1);
    localparam logic [NW:0]   N_REF    = (NW + 1)'(SEQ_LEN);
    localparam logic [MW:0]   M_REF    = (MW + 1)'(BLK_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        EVAL1,
        EVAL2,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [NW-1:0]   bitCnt_q;
    logic [NW-1:0]   n1_q;
    logic [MW-1:0]   blkCnt_q;
    logic [MW-1:0]   c_q;
    logic [MW-1:0]   d_q;
    logic            sqPend_q;
    logic [CW-1:0]   chiAcc_q;
    logic            nPass1_q;
    logic            nPass2_q;
    logic            nBlkOK_q;
    logic            done_q;

    logic            accept;
    logic            blkEnd;
    logic            seqEnd;
    logic            enterRun;
    logic [MW-1:0]   cInc;
    logic [MW:0]     twoC;
    logic [MW-1:0]   dNext;
    logic [NW:0]     twoN1;
    logic [NW:0]     sAbs;
    logic [2*MW-1:0] sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = (state_q == RUN) && bus.rnd_valid;
        blkEnd   = accept && (blkCnt_q == LAST_BLK);
        seqEnd   = accept && (bitCnt_q == LAST_BIT);
        case (state_q)
            IDLE:    if (bus.start || bus.cont_mode) state_d = RUN;
            RUN:     if (seqEnd) state_d = EVAL1;
            EVAL1:   state_d = EVAL2;
            EVAL2:   state_d = DONE;
            DONE:    state_d = bus.cont_mode ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        enterRun = (state_q != RUN) && (state_d == RUN);
    end

    // Block deviation is taken from the count including the bit just accepted,
    // so it is valid on the same edge that closes the block.
    always_comb begin
        cInc  = c_q + MW'(bus.RND_in);
        twoC  = {cInc, 1'b0};
        dNext = (twoC >= M_REF) ? MW'(twoC - M_REF) : MW'(M_REF - twoC);
        twoN1 = {n1_q, 1'b0};
        sAbs  = (twoN1 >= N_REF) ? (twoN1 - N_REF) : (N_REF - twoN1);
        sq    = {{MW{1'b0}}, d_q} * {{MW{1'b0}}, d_q};
    end

    // The square of each block deviation is folded into chiAcc one cycle after
    // the block closes; for the final block that cycle is EVAL1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt_q <= '0;
            n1_q     <= '0;
            blkCnt_q <= '0;
            c_q      <= '0;
            d_q      <= '0;
            sqPend_q <= 1'b0;
            chiAcc_q <= '0;
            nPass1_q <= 1'b1;
            nPass2_q <= 1'b1;
            nBlkOK_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == EVAL2);
            if (enterRun) begin
                bitCnt_q <= '0;
                n1_q     <= '0;
                blkCnt_q <= '0;
                c_q      <= '0;
                sqPend_q <= 1'b0;
                chiAcc_q <= '0;
            end else begin
                if (accept) begin
                    bitCnt_q <= bitCnt_q + NW'(1);
                    n1_q     <= n1_q + NW'(bus.RND_in);
                    if (blkEnd) begin
                        c_q      <= '0;
                        blkCnt_q <= '0;
                        d_q      <= dNext;
                        nBlkOK_q <= (dNext > MW'(BLK_DEV_MAX));
                    end else begin
                        c_q      <= cInc;
                        blkCnt_q <= blkCnt_q + MW'(1);
                    end
                end
                sqPend_q <= blkEnd;
                if (sqPend_q) begin
                    chiAcc_q <= chiAcc_q + CW'(sq);
                end
            end
            if (state_q == EVAL2) begin
                nPass1_q <= (sAbs > (NW + 1)'(S_MAX));
                nPass2_q <= (chiAcc_q > CW'(CHI_MAX));
            end
        end
    end

    assign bus.nPass1 = nPass1_q;
    assign bus.nPass2 = nPass2_q;
    assign bus.nBlkOK = nBlkOK_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == RUN) || (state_q == EVAL1) || (state_q == EVAL2);

endmodule
